// File: rtl/rgb888_frame_packer.sv
// Packs a frame of RGB888 pixels into a 16-bit word buffer (RGB565 truncated or
// rounded, or RGB555). A synchronous read port gives access to the buffer.
module rgb888_frame_packer #(
  parameter int DEPTH = 130560,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic [23:0]   i_data_rgb888,
  input  logic          i_valid,
  input  logic          i_Clk_en,
  input  logic [1:0]    i_mode,
  input  logic          i_start,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [15:0]   o_rd_data,
  output logic          o_rd_valid,
  output logic [AW-1:0] o_wr_addr,
  output logic          o_done_valid,
  output logic          o_busy,
  output logic          o_overflow,
  output logic [1:0]    o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

  state_t      state;
  logic [1:0]  mode_q;
  logic [15:0] reg_file [DEPTH];

  // Handshake: there is no back-pressure. A pixel is transferred on any rising
  // edge where i_valid && i_Clk_en; the packer always takes it (and may drop it
  // when idle, complete, or when i_start arrives on the same edge).
  logic accept;
  logic wr_en;
  assign accept  = i_valid && i_Clk_en;
  assign wr_en   = accept && !i_start && !iRst && (state == FILL);
  assign o_state = state;

  logic [8:0]  r_rnd, g_rnd, b_rnd;
  logic [4:0]  r5_rnd, b5_rnd;
  logic [5:0]  g6_rnd;
  logic [15:0] conv_pix;

  // Rounded mode works on 9-bit sums so a carry out saturates instead of wrapping.
  always_comb begin
    r_rnd  = {1'b0, i_data_rgb888[23:16]} + 9'd4;
    g_rnd  = {1'b0, i_data_rgb888[15:8]}  + 9'd2;
    b_rnd  = {1'b0, i_data_rgb888[7:0]}   + 9'd4;
    r5_rnd = r_rnd[8] ? 5'd31 : r_rnd[7:3];
    g6_rnd = g_rnd[8] ? 6'd63 : g_rnd[7:2];
    b5_rnd = b_rnd[8] ? 5'd31 : b_rnd[7:3];
    case (mode_q)
      2'b01:   conv_pix = {r5_rnd, g6_rnd, b5_rnd};
      2'b10:   conv_pix = {1'b0, i_data_rgb888[23:19], i_data_rgb888[15:11],
                           i_data_rgb888[7:3]};
      default: conv_pix = {i_data_rgb888[23:19], i_data_rgb888[15:10],
                           i_data_rgb888[7:3]};
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state        <= IDLE;
      o_wr_addr    <= '0;
      o_done_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_overflow   <= 1'b0;
      mode_q       <= 2'b00;
    end else if (i_start) begin
      state        <= FILL;
      o_wr_addr    <= '0;
      o_done_valid <= 1'b0;
      o_busy       <= 1'b1;
      o_overflow   <= 1'b0;
      mode_q       <= (i_mode == 2'b11) ? 2'b00 : i_mode;
    end else if (accept) begin
      case (state)
        FILL: begin
          if (o_wr_addr == LAST_ADDR) begin
            state        <= DONE;
            o_wr_addr    <= '0;
            o_done_valid <= 1'b1;
            o_busy       <= 1'b0;
          end else begin
            o_wr_addr <= o_wr_addr + 1'b1;
          end
        end
        DONE:    o_overflow <= 1'b1;
        default: ;
      endcase
    end
  end

  // Buffer contents survive reset, so the write port has no reset branch.
  always_ff @(posedge iClk) begin
    if (wr_en) reg_file[o_wr_addr] <= conv_pix;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      o_rd_data  <= 16'h0000;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        if ({1'b0, i_rd_addr} >= DEPTH_W) o_rd_data <= 16'h0000;
        else                              o_rd_data <= reg_file[i_rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_rgb888_frame_packer.sv
// Self-checking bench for rgb888_frame_packer with a 16-word frame and a
// clock enable that pulses once every 16 cycles.
module tb_rgb888_frame_packer;

  localparam int DEPTH = 16;
  localparam int AW    = 5;

  logic          tb_clk = 1'b0;
  logic          tb_rst_n;
  logic [23:0]   i_data_rgb888;
  logic          i_valid;
  logic          i_Clk_en;
  logic [1:0]    i_mode;
  logic          i_start;
  logic          i_rd_en;
  logic [AW-1:0] i_rd_addr;
  logic [15:0]   o_rd_data;
  logic          o_rd_valid;
  logic [AW-1:0] o_wr_addr;
  logic          o_done_valid;
  logic          o_busy;
  logic          o_overflow;
  logic [1:0]    o_state;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] mem_model [DEPTH];
  logic [1:0]  model_mode = 2'b00;
  int          model_addr = 0;
  bit          model_fill = 1'b0;

  rgb888_frame_packer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .iClk          (tb_clk),
    .iRst          (tb_rst_n),
    .i_data_rgb888 (i_data_rgb888),
    .i_valid       (i_valid),
    .i_Clk_en      (i_Clk_en),
    .i_mode        (i_mode),
    .i_start       (i_start),
    .i_rd_en       (i_rd_en),
    .i_rd_addr     (i_rd_addr),
    .o_rd_data     (o_rd_data),
    .o_rd_valid    (o_rd_valid),
    .o_wr_addr     (o_wr_addr),
    .o_done_valid  (o_done_valid),
    .o_busy        (o_busy),
    .o_overflow    (o_overflow),
    .o_state       (o_state)
  );

  // clock / reset / enable strobe
  always #5 tb_clk = ~tb_clk;

  logic [3:0] en_cnt = 4'd0;
  always @(posedge tb_clk) en_cnt <= en_cnt + 4'd1;
  assign i_Clk_en = (en_cnt == 4'd15);

  // reference conversion
  function automatic logic [15:0] conv(input logic [1:0] m, input logic [23:0] p);
    int r, g, b;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    case (m)
      2'b01: begin
        r = (r + 4) / 8; if (r > 31) r = 31;
        g = (g + 2) / 4; if (g > 63) g = 63;
        b = (b + 4) / 8; if (b > 31) b = 31;
        return {5'(r), 6'(g), 5'(b)};
      end
      2'b10:   return {1'b0, 5'(r / 8), 5'(g / 8), 5'(b / 8)};
      default: return {5'(r / 8), 6'(g / 4), 5'(b / 8)};
    endcase
  endfunction

  // driver tasks
  task automatic wait_en();
    int n = 0;
    @(negedge tb_clk);
    while (!i_Clk_en && n < 40) begin
      @(negedge tb_clk);
      n++;
    end
    if (!i_Clk_en) begin
      checks++; errors++;
      $display("FAIL wait_en: no clock enable within %0d cycles", n);
    end
  endtask

  task automatic model_accept(input logic [23:0] d);
    if (model_fill) begin
      mem_model[model_addr] = conv(model_mode, d);
      model_addr++;
      if (model_addr == DEPTH) begin
        model_addr = 0;
        model_fill = 1'b0;
      end
    end
  endtask

  task automatic send_pixel(input logic [23:0] d);
    wait_en();
    i_valid       = 1'b1;
    i_data_rgb888 = d;
    model_accept(d);
    @(negedge tb_clk);
    i_valid = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] m);
    @(negedge tb_clk);
    i_start = 1'b1;
    i_mode  = m;
    @(negedge tb_clk);
    i_start    = 1'b0;
    model_mode = (m == 2'b11) ? 2'b00 : m;
    model_addr = 0;
    model_fill = 1'b1;
  endtask

  task automatic rd_check(input logic [AW-1:0] a);
    logic [15:0] exp;
    @(negedge tb_clk);
    i_rd_en   = 1'b1;
    i_rd_addr = a;
    exp_q.push_back((a >= AW'(DEPTH)) ? 16'h0000 : mem_model[a[3:0]]);
    @(negedge tb_clk);
    i_rd_en = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (o_rd_valid !== 1'b1 || o_rd_data !== exp) begin
      errors++;
      $display("FAIL rd_addr_%0d: got valid=%b data=%h expected valid=1 data=%h",
               a, o_rd_valid, o_rd_data, exp);
    end
  endtask

  // scenarios
  task automatic test_reset();
    tb_rst_n = 1'b1;
    repeat (3) @(negedge tb_clk);
    tb_rst_n = 1'b0;
    @(negedge tb_clk);
    checks++;
    if ({o_wr_addr, o_done_valid, o_busy, o_overflow, o_rd_valid, o_rd_data, o_state}
        !== '0) begin
      errors++;
      $display("FAIL reset_outputs: wr=%h done=%b busy=%b ovf=%b rv=%b rd=%h st=%h expected all 0",
               o_wr_addr, o_done_valid, o_busy, o_overflow, o_rd_valid, o_rd_data, o_state);
    end
  endtask

  task automatic test_mode00();
    do_start(2'b00);
    checks++;
    if (o_busy !== 1'b1 || o_wr_addr !== '0) begin
      errors++;
      $display("FAIL start_fill: busy=%b wr=%h expected busy=1 wr=0", o_busy, o_wr_addr);
    end
    send_pixel(24'hFF8040);
    checks++;
    if (dut.reg_file[0] !== 16'hFC08 || o_wr_addr !== AW'(1)) begin
      errors++;
      $display("FAIL mode00_pixel: word=%h wr=%h expected word=fc08 wr=1",
               dut.reg_file[0], o_wr_addr);
    end
    do_start(2'b11);
    send_pixel(24'h123456);
    rd_check(0);
  endtask

  task automatic test_mode01();
    do_start(2'b01);
    send_pixel(24'h0C0A0C);
    send_pixel(24'hFCFEFD);
    checks++;
    if (dut.reg_file[0] !== 16'h1062 || dut.reg_file[1] !== 16'hFFFF) begin
      errors++;
      $display("FAIL mode01_round: w0=%h w1=%h expected w0=1062 w1=ffff",
               dut.reg_file[0], dut.reg_file[1]);
    end
    send_pixel(24'h7F7F7F);
    rd_check(2);
  endtask

  task automatic test_mode10();
    do_start(2'b10);
    send_pixel(24'hFF8040);
    i_mode = 2'b01;
    send_pixel(24'hFF8040);
    checks++;
    if (dut.reg_file[0] !== 16'h7E08 || dut.reg_file[1] !== 16'h7E08) begin
      errors++;
      $display("FAIL mode10_latched: w0=%h w1=%h expected both 7e08",
               dut.reg_file[0], dut.reg_file[1]);
    end
  endtask

  task automatic test_full_frame();
    logic [15:0] w0;
    do_start(2'b00);
    for (int j = 0; j < DEPTH; j++) begin
      if (j == DEPTH - 1) begin
        checks++;
        if (o_done_valid !== 1'b0 || o_wr_addr !== AW'(DEPTH - 1)) begin
          errors++;
          $display("FAIL before_last: done=%b wr=%h expected done=0 wr=%h",
                   o_done_valid, o_wr_addr, AW'(DEPTH - 1));
        end
      end
      send_pixel(24'(j + 100));
    end
    checks++;
    if (o_done_valid !== 1'b1 || o_busy !== 1'b0 || o_wr_addr !== '0 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL frame_done: done=%b busy=%b wr=%h ovf=%b expected done=1 busy=0 wr=0 ovf=0",
               o_done_valid, o_busy, o_wr_addr, o_overflow);
    end
    for (int a = 0; a < DEPTH; a++) rd_check(AW'(a));
    w0 = mem_model[0];
    send_pixel(24'hABCDEF);
    checks++;
    if (o_overflow !== 1'b1 || dut.reg_file[0] !== w0 || o_done_valid !== 1'b1) begin
      errors++;
      $display("FAIL overflow: ovf=%b w0=%h done=%b expected ovf=1 w0=%h done=1",
               o_overflow, dut.reg_file[0], o_done_valid, w0);
    end
  endtask

  task automatic test_restart();
    logic [15:0] exp;
    do_start(2'b00);
    checks++;
    if (o_overflow !== 1'b0 || o_done_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_clears: ovf=%b done=%b expected 0 0", o_overflow, o_done_valid);
    end
    for (int j = 0; j < 5; j++) send_pixel(24'($urandom_range(0, 24'hFFFFFF)));
    wait_en();
    i_start       = 1'b1;
    i_valid       = 1'b1;
    i_data_rgb888 = 24'h00FF00;
    model_addr    = 0;
    model_fill    = 1'b1;
    @(negedge tb_clk);
    i_start = 1'b0;
    i_valid = 1'b0;
    checks++;
    if (o_wr_addr !== '0 || o_done_valid !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL restart: wr=%h done=%b busy=%b expected wr=0 done=0 busy=1",
               o_wr_addr, o_done_valid, o_busy);
    end
    send_pixel(24'h4080C0);
    checks++;
    if (dut.reg_file[0] !== conv(2'b00, 24'h4080C0) || o_wr_addr !== AW'(1)) begin
      errors++;
      $display("FAIL restart_overwrite: w0=%h wr=%h expected w0=%h wr=1",
               dut.reg_file[0], o_wr_addr, conv(2'b00, 24'h4080C0));
    end
    // read at the address being written on the same edge
    wait_en();
    i_valid       = 1'b1;
    i_data_rgb888 = 24'hFFFFFF;
    i_rd_en       = 1'b1;
    i_rd_addr     = AW'(1);
    exp_q.push_back(mem_model[1]);
    model_accept(24'hFFFFFF);
    @(negedge tb_clk);
    i_valid = 1'b0;
    i_rd_en = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (o_rd_valid !== 1'b1 || o_rd_data !== exp || dut.reg_file[1] !== 16'hFFFF) begin
      errors++;
      $display("FAIL read_first: rv=%b rd=%h w1=%h expected rv=1 rd=%h w1=ffff",
               o_rd_valid, o_rd_data, dut.reg_file[1], exp);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [15:0] w0;
    @(negedge tb_clk);
    i_rd_en   = 1'b1;
    i_rd_addr = AW'(4);
    tb_rst_n  = 1'b1;
    @(negedge tb_clk);
    tb_rst_n   = 1'b0;
    i_rd_en    = 1'b0;
    model_fill = 1'b0;
    checks++;
    if ({o_wr_addr, o_done_valid, o_busy, o_overflow, o_rd_valid, o_rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_mid_fill: wr=%h done=%b busy=%b ovf=%b rv=%b rd=%h expected all 0",
               o_wr_addr, o_done_valid, o_busy, o_overflow, o_rd_valid, o_rd_data);
    end
    w0 = mem_model[0];
    send_pixel(24'h010203);
    checks++;
    if (o_wr_addr !== '0 || o_busy !== 1'b0 || o_overflow !== 1'b0 || dut.reg_file[0] !== w0) begin
      errors++;
      $display("FAIL idle_ignore: wr=%h busy=%b ovf=%b w0=%h expected wr=0 busy=0 ovf=0 w0=%h",
               o_wr_addr, o_busy, o_overflow, dut.reg_file[0], w0);
    end
    rd_check(AW'(3));
    rd_check(AW'(20));
    @(negedge tb_clk);
    checks++;
    if (o_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_valid_drop: got %b expected 0", o_rd_valid);
    end
  endtask

  initial begin
    tb_rst_n      = 1'b1;
    i_data_rgb888 = '0;
    i_valid       = 1'b0;
    i_mode        = 2'b00;
    i_start       = 1'b0;
    i_rd_en       = 1'b0;
    i_rd_addr     = '0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 16'h0000;
    test_reset();
    test_mode00();
    test_mode01();
    test_mode10();
    test_full_frame();
    test_restart();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
